// File: rtl/conv_window_3x4_generator_pkg.sv
// Shared types and geometry constants for the 3x4 convolution window generator.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

package conv_window_3x4_generator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } fsm_state_t;

    localparam int WIN_ROWS      = 3;
    localparam int WIN_COLS      = 4;
    localparam int WIN_ELEMS     = WIN_ROWS * WIN_COLS;
    localparam int CFG_WIDTH     = 10;
    localparam int MIN_ROW_WORDS = 4;
    localparam int MIN_COL_ROWS  = 3;

    function automatic logic cfg_legal(input logic [CFG_WIDTH-1:0] row_words,
                                       input logic [CFG_WIDTH-1:0] col_rows);
        return (row_words >= CFG_WIDTH'(MIN_ROW_WORDS)) &&
               (col_rows  >= CFG_WIDTH'(MIN_COL_ROWS));
    endfunction

endpackage

// File: rtl/conv_window_3x4_generator_if.sv
// Stream-in / window-out bus of the window generator; the producer/consumer side
// uses master, the generator uses slave.
interface conv_window_3x4_generator_if #(
    parameter int FEATURE_WIDTH = `FEATURE_WIDTH
);
    import conv_window_3x4_generator_pkg::*;

    logic                             start;
    logic [CFG_WIDTH-1:0]             row_words;
    logic [CFG_WIDTH-1:0]             col_rows;
    logic                             in_valid;
    logic [2*FEATURE_WIDTH-1:0]       in_data;
    logic                             in_ready;
    logic                             win_valid;
    logic [WIN_ELEMS*FEATURE_WIDTH-1:0] win_data;
    logic                             win_last;
    logic                             busy;
    logic                             done;

    modport master (
        output start, row_words, col_rows, in_valid, in_data,
        input  in_ready, win_valid, win_data, win_last, busy, done
    );

    modport slave (
        input  start, row_words, col_rows, in_valid, in_data,
        output in_ready, win_valid, win_data, win_last, busy, done
    );

endinterface

// File: rtl/conv_window_3x4_generator_ram.sv
// RAM-based line delay: the output seen while word k is presented is word k-(shift_size+2),
// because the registered read already adds one word of delay on top of the ring length.
module ram_base_shift_register_for_cache #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  system_clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] shift_size,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] ptr;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (wr_en) begin
            ptr <= (ptr >= shift_size) ? '0 : ptr + 1'b1;
        end
    end

    // Read-before-write on the same slot gives a ring of shift_size+1 entries.
    always_ff @(posedge system_clk) begin
        if (wr_en) begin
            mem[ptr] <= din;
            dout     <= mem[ptr];
        end
    end

endmodule

// File: rtl/conv_window_3x4_generator.sv
// Builds 3-row x 4-column feature windows from a two-features-per-word raster stream
// using two cascaded one-row line delays and a one-word column register per row.
module conv_window_3x4_generator
    import conv_window_3x4_generator_pkg::*;
#(
    parameter int FEATURE_WIDTH = `FEATURE_WIDTH
) (
    input  logic                        system_clk,
    input  logic                        rst_n,
    conv_window_3x4_generator_if.slave  bus
);

    localparam int WORD_W = 2 * FEATURE_WIDTH;
    localparam int WIN_W  = WIN_ELEMS * FEATURE_WIDTH;

    fsm_state_t           state, state_next;
    logic [CFG_WIDTH-1:0] row_words_q, col_rows_q;
    logic [CFG_WIDTH-1:0] col_cnt, row_cnt;
    logic [CFG_WIDTH-1:0] shift_size;

    logic                 start_ok, accept, in_ready_int;
    logic                 col_end, fill_end, frame_end, win_form;
    logic [WORD_W-1:0]    line1, line2;
    logic [WORD_W-1:0]    prev0, prev1, prev2;
    logic [WIN_W-1:0]     win_next;

    logic                 win_valid_q, win_last_q, done_q;
    logic [WIN_W-1:0]     win_data_q;

    assign start_ok     = bus.start && (state == IDLE) && cfg_legal(bus.row_words, bus.col_rows);
    assign in_ready_int = (state == FILL) || (state == RUN);
    assign accept       = bus.in_valid && in_ready_int;
    assign col_end      = (col_cnt == row_words_q - 10'd1);
    assign fill_end     = accept && (row_cnt == 10'd2) && (col_cnt == '0);
    assign frame_end    = accept && col_end && (row_cnt == col_rows_q - 10'd1);
    assign win_form     = accept && (row_cnt >= 10'd2) && (col_cnt != '0);
    assign shift_size   = row_words_q - 10'd2;

    // Each window row is {current word, previous word}; row 0 is the oldest (two rows back).
    assign win_next = {bus.in_data, prev2, line1, prev1, line2, prev0};

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_ok)  state_next = FILL;
            FILL:    if (fill_end)  state_next = RUN;
            RUN:     if (frame_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            row_words_q <= '0;
            col_rows_q  <= '0;
            col_cnt     <= '0;
            row_cnt     <= '0;
        end else if (start_ok) begin
            row_words_q <= bus.row_words;
            col_rows_q  <= bus.col_rows;
            col_cnt     <= '0;
            row_cnt     <= '0;
        end else if (accept) begin
            if (col_end) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + 10'd1;
            end else begin
                col_cnt <= col_cnt + 10'd1;
            end
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            prev0 <= '0;
            prev1 <= '0;
            prev2 <= '0;
        end else if (accept) begin
            prev0 <= line2;
            prev1 <= line1;
            prev2 <= bus.in_data;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            win_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            win_valid_q <= win_form;
            win_last_q  <= frame_end;
            done_q      <= (state == DONE);
            if (win_form) begin
                win_data_q <= win_next;
            end
        end
    end

    ram_base_shift_register_for_cache #(
        .DATA_WIDTH (WORD_W),
        .ADDR_WIDTH (CFG_WIDTH)
    ) u_line_delay_1 (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .wr_en      (accept),
        .shift_size (shift_size),
        .din        (bus.in_data),
        .dout       (line1)
    );

    ram_base_shift_register_for_cache #(
        .DATA_WIDTH (WORD_W),
        .ADDR_WIDTH (CFG_WIDTH)
    ) u_line_delay_2 (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .clear      (start_ok),
        .wr_en      (accept),
        .shift_size (shift_size),
        .din        (line1),
        .dout       (line2)
    );

    assign bus.in_ready  = in_ready_int;
    assign bus.busy      = (state != IDLE);
    assign bus.win_valid = win_valid_q;
    assign bus.win_last  = win_last_q;
    assign bus.win_data  = win_data_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_window_3x4_generator.sv
// Self-checking bench for conv_window_3x4_generator: directed and random frames
// compared against a window list computed directly from the frame's word array.
`ifndef FEATURE_WIDTH
`define FEATURE_WIDTH 8
`endif

module tb_conv_window_3x4_generator;
    import conv_window_3x4_generator_pkg::*;

    localparam int FW = `FEATURE_WIDTH;
    localparam int WW = 2 * FW;
    localparam int DW = WIN_ELEMS * FW;

    logic system_clk = 1'b0;
    logic rst_n      = 1'b0;
    always #5 system_clk = ~system_clk;

    conv_window_3x4_generator_if #(.FEATURE_WIDTH(FW)) bus ();

    conv_window_3x4_generator #(.FEATURE_WIDTH(FW)) dut (
        .system_clk (system_clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [WW-1:0] frame_words[$];
    logic [DW:0]   got_q[$];
    int            got_cycle_q[$];
    int            done_cycle_q[$];
    int            accept_cycle_q[$];
    logic [DW-1:0] prev_data;
    logic          prev_rst = 1'b0;

    task automatic check_val(input string tag, input logic [DW:0] observed, input logic [DW:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Output monitor, sampled mid-cycle away from the active edge.
    always @(negedge system_clk) begin
        cycle++;
        if (rst_n) begin
            if (bus.win_valid) begin
                got_q.push_back({bus.win_last, bus.win_data});
                got_cycle_q.push_back(cycle);
            end
            if (bus.done) done_cycle_q.push_back(cycle);
            if (bus.in_valid && bus.in_ready) accept_cycle_q.push_back(cycle);
            if (!bus.win_valid && prev_rst) begin
                checks++;
                assert (bus.win_data === prev_data)
                else begin
                    errors++;
                    $error("[TB] FAIL win_data_hold observed=%h expected=%h", bus.win_data, prev_data);
                end
            end
        end
        prev_data = bus.win_data;
        prev_rst  = rst_n;
    end

    task automatic gen_words(input int n, input int r, input bit rnd);
        frame_words.delete();
        for (int row = 0; row < r; row++) begin
            for (int w = 0; w < n; w++) begin
                if (rnd) frame_words.push_back(WW'($urandom));
                else     frame_words.push_back({FW'(row*16 + 2*w + 1), FW'(row*16 + 2*w)});
            end
        end
    endtask

    // mode 0: continuous valid, 1: alternating 1,0,1,0, 2: random gaps
    task automatic apply_stimulus(input int n, input int r, input int mode,
                                  input int mid_start, input int abort_at, output bit aborted);
        int idx    = 0;
        int step   = 0;
        int budget = n * r * 5 + 100;
        logic v;
        aborted = 1'b0;
        got_q.delete();
        got_cycle_q.delete();
        done_cycle_q.delete();
        accept_cycle_q.delete();
        @(posedge system_clk); #1;
        bus.start     = 1'b1;
        bus.row_words = 10'(n);
        bus.col_rows  = 10'(r);
        @(posedge system_clk); #1;
        bus.start = 1'b0;
        while (idx < n * r && budget > 0) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (step % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid = v;
            bus.in_data  = frame_words[idx];
            if (mid_start > 0 && idx == mid_start) begin
                bus.start     = 1'b1;
                bus.row_words = 10'd5;
                bus.col_rows  = 10'd3;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge system_clk);
            if (bus.in_valid && bus.in_ready) idx++;
            if (abort_at > 0 && got_q.size() >= abort_at) begin
                rst_n   = 1'b0;
                aborted = 1'b1;
                break;
            end
            @(posedge system_clk); #1;
            step++;
            budget--;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (!aborted) begin
            check_val("feed_complete", DW'(idx), DW'(n * r));
            repeat (5) @(posedge system_clk);
            #1;
        end
    endtask

    task automatic check_output(input string tag, input int n, input int r, input bit chk_latency);
        logic [DW:0]   exp_q[$];
        logic [DW:0]   e;
        logic [WW-1:0] pw, cw;
        int            last_c;
        for (int row = 2; row < r; row++) begin
            for (int w = 1; w < n; w++) begin
                e = '0;
                for (int rr = 0; rr < 3; rr++) begin
                    pw = frame_words[(row - 2 + rr) * n + w - 1];
                    cw = frame_words[(row - 2 + rr) * n + w];
                    e[(rr*4 + 0)*FW +: FW] = pw[FW-1:0];
                    e[(rr*4 + 1)*FW +: FW] = pw[WW-1:FW];
                    e[(rr*4 + 2)*FW +: FW] = cw[FW-1:0];
                    e[(rr*4 + 3)*FW +: FW] = cw[WW-1:FW];
                end
                e[DW] = (row == r - 1) && (w == n - 1);
                exp_q.push_back(e);
            end
        end
        check_val({tag, "_count"}, DW'(got_q.size()), DW'((r - 2) * (n - 1)));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_val($sformatf("%s_win%0d", tag, i), got_q[i], exp_q[i]);
        end
        last_c = (got_cycle_q.size() > 0) ? got_cycle_q[got_cycle_q.size() - 1] : -100;
        check_val({tag, "_done_count"}, DW'(done_cycle_q.size()), DW'(1));
        if (done_cycle_q.size() > 0)
            check_val({tag, "_done_after_last"}, DW'(done_cycle_q[0]), DW'(last_c + 1));
        if (chk_latency && accept_cycle_q.size() > 2*n + 1 && got_cycle_q.size() > 0)
            check_val({tag, "_first_latency"}, DW'(got_cycle_q[0]), DW'(accept_cycle_q[2*n + 1] + 1));
        check_val({tag, "_busy_after"}, DW'(bus.busy), DW'(0));
        check_val({tag, "_ready_after"}, DW'(bus.in_ready), DW'(0));
    endtask

    task automatic check_first_pattern(input string tag);
        logic [DW:0] e;
        e = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int c = 0; c < 4; c++)
                e[(rr*4 + c)*FW +: FW] = FW'(rr*16 + c);
        if (got_q.size() > 0) check_val(tag, {1'b0, got_q[0][DW-1:0]}, e);
        else                  check_val(tag, DW'(got_q.size()), DW'(1));
    endtask

    task automatic illegal_start(input string tag, input int n, input int r);
        got_q.delete();
        @(posedge system_clk); #1;
        bus.start     = 1'b1;
        bus.row_words = 10'(n);
        bus.col_rows  = 10'(r);
        bus.in_valid  = 1'b1;
        @(posedge system_clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge system_clk);
            check_val({tag, "_busy"}, DW'(bus.busy), DW'(0));
            check_val({tag, "_ready"}, DW'(bus.in_ready), DW'(0));
        end
        @(posedge system_clk); #1;
        bus.in_valid = 1'b0;
        check_val({tag, "_no_windows"}, DW'(got_q.size()), DW'(0));
    endtask

    initial begin
        bit ab;
        bus.start     = 1'b0;
        bus.row_words = '0;
        bus.col_rows  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge system_clk);
        @(negedge system_clk);
        check_val("rst_in_ready", DW'(bus.in_ready), DW'(0));
        check_val("rst_busy", DW'(bus.busy), DW'(0));
        check_val("rst_done", DW'(bus.done), DW'(0));
        check_val("rst_win_valid", DW'(bus.win_valid), DW'(0));
        check_val("rst_win_last", DW'(bus.win_last), DW'(0));
        check_val("rst_win_data", {1'b0, bus.win_data}, '0);
        @(posedge system_clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge system_clk);
        #1;

        $display("[TB] frame 8x4 continuous");
        gen_words(8, 4, 1'b0);
        apply_stimulus(8, 4, 0, 0, 0, ab);
        check_output("A", 8, 4, 1'b1);
        check_first_pattern("A_first");

        $display("[TB] frame 8x4 alternating valid");
        apply_stimulus(8, 4, 1, 0, 0, ab);
        check_output("B", 8, 4, 1'b0);

        $display("[TB] illegal configurations");
        illegal_start("ill_rw3", 3, 5);
        illegal_start("ill_cr2", 6, 2);

        $display("[TB] start pulsed during RUN");
        gen_words(6, 5, 1'b1);
        apply_stimulus(6, 5, 2, 16, 0, ab);
        check_output("midstart", 6, 5, 1'b0);

        $display("[TB] reset after 10 windows");
        gen_words(8, 4, 1'b0);
        apply_stimulus(8, 4, 0, 0, 10, ab);
        check_val("abort_taken", DW'(ab), DW'(1));
        #1;
        check_val("abort_win_valid", DW'(bus.win_valid), DW'(0));
        check_val("abort_busy", DW'(bus.busy), DW'(0));
        check_val("abort_win_data", {1'b0, bus.win_data}, '0);
        @(posedge system_clk); #1;
        rst_n = 1'b1;
        got_q.delete();
        repeat (6) @(posedge system_clk);
        #1;
        check_val("abort_no_stale", DW'(got_q.size()), DW'(0));
        gen_words(4, 3, 1'b0);
        apply_stimulus(4, 3, 0, 0, 0, ab);
        check_output("after_abort", 4, 3, 1'b1);
        check_first_pattern("after_abort_first");

        $display("[TB] random frames with gaps");
        for (int k = 0; k < 3; k++) begin
            int n, r;
            n = $urandom_range(4, 9);
            r = $urandom_range(3, 6);
            gen_words(n, r, 1'b1);
            apply_stimulus(n, r, 2, 0, 0, ab);
            check_output($sformatf("rnd%0d", k), n, r, 1'b0);
        end

        $display("[TB] wide frame 1023x3");
        gen_words(1023, 3, 1'b1);
        apply_stimulus(1023, 3, 0, 0, 0, ab);
        check_output("wide", 1023, 3, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
